// File: rtl/ahb2_pkg.sv
// ahb2_pkg: shared encodings and types for the two-master AHB2 memory arbiter.
//   HTRANS_IDLE / HTRANS_NONSEQ : transfer-type encodings driven to the slave.
//   HRESP_OKAY                  : response returned to a master that does not
//                                 own the current data phase.
//   mst_id_t                    : master index (0 or 1).
package ahb2_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;

  typedef logic mst_id_t;

endpackage

// File: rtl/ahb2_arb_req_buf.sv
// ahb2_arb_req_buf: per-master request buffer for ahb2_mem_arb.
//
// Holds one buffered address phase (valid, addr, write) for a master that
// lost arbitration or arrived while the slave was stalling. Presents the
// master's candidate request (buffered entry first, else the live port) and
// generates the hreadyo returned to that master.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   hsel, htrans_act   master select and htrans[1] (active transfer)
//   haddr, hwrite      master address-phase signals
//   grant              this master is granted the slave address phase now
//   dp_mine            this master owns the current slave data phase
//   s_hreadyo          slave ready
//   cand               master has a request this cycle (buffered or new)
//   cand_addr/_write   address-phase source for the candidate
//   hreadyo            ready returned to the master
//
// Handshake: a master address phase is accepted on a rising edge where
// hsel & htrans_act & hreadyo; it is then either granted in that cycle or
// captured into the buffer, and hreadyo is held low until the buffered
// entry is granted.
module ahb2_arb_req_buf
  import ahb2_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hsel,
  input  logic                  htrans_act,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  hwrite,
  input  logic                  grant,
  input  logic                  dp_mine,
  input  logic                  s_hreadyo,
  output logic                  cand,
  output logic [ADDR_WIDTH-1:0] cand_addr,
  output logic                  cand_write,
  output logic                  hreadyo
);

  logic                  pend_valid_q, pend_valid_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q,  pend_addr_d;
  logic                  pend_write_q, pend_write_d;
  logic                  new_req;

  // While a request is buffered hreadyo is low, so new_req cannot fire and
  // the buffered entry can never be overwritten or duplicated.
  always_comb begin
    hreadyo = 1'b1;
    if (pend_valid_q) begin
      hreadyo = 1'b0;
    end else if (dp_mine) begin
      hreadyo = s_hreadyo;
    end
  end

  assign new_req    = hsel & htrans_act & hreadyo;
  assign cand       = pend_valid_q | new_req;
  assign cand_addr  = pend_valid_q ? pend_addr_q  : haddr;
  assign cand_write = pend_valid_q ? pend_write_q : hwrite;

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_write_d = pend_write_q;
    if (grant) begin
      // Granted source (buffered or live) has reached the slave.
      pend_valid_d = 1'b0;
    end else if (new_req) begin
      // Lost arbitration or slave stalled: hold the address phase.
      pend_valid_d = 1'b1;
      pend_addr_d  = haddr;
      pend_write_d = hwrite;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_write_q <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_write_q <= pend_write_d;
    end
  end

endmodule

// File: rtl/ahb2_mem_arb.sv
// ahb2_mem_arb: two-master AHB2 arbiter in front of a single-port memory.
//
// Each beat is arbitrated on its own as NONSEQ (hburst/hsize/HSEQ ignored).
// The losing master's address phase is buffered in ahb2_arb_req_buf and
// costs it one wait state per lost round. Write data, read data and
// response follow the data-phase owner.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   mN_hsel/haddr/htrans/hwrite/hwdata  master N request (N = 0,1)
//   mN_hrdata/hreadyo/hresp          master N return path
//   s_hsel/haddr/htrans/hwrite/hwdata/hreadyi  to the memory slave
//   s_hrdata/hreadyo/hresp           from the memory slave
//
// Configuration macro:
//   AHB2_MEM_ARB_FIXED_PRIO_EN  defined   -> master 0 always wins a conflict
//                               undefined -> round-robin on last grant
module ahb2_mem_arb
  import ahb2_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_hsel,
  input  logic [ADDR_WIDTH-1:0] m0_haddr,
  input  logic [1:0]            m0_htrans,
  input  logic                  m0_hwrite,
  input  logic [DATA_WIDTH-1:0] m0_hwdata,
  output logic [DATA_WIDTH-1:0] m0_hrdata,
  output logic                  m0_hreadyo,
  output logic [1:0]            m0_hresp,
  input  logic                  m1_hsel,
  input  logic [ADDR_WIDTH-1:0] m1_haddr,
  input  logic [1:0]            m1_htrans,
  input  logic                  m1_hwrite,
  input  logic [DATA_WIDTH-1:0] m1_hwdata,
  output logic [DATA_WIDTH-1:0] m1_hrdata,
  output logic                  m1_hreadyo,
  output logic [1:0]            m1_hresp,
  output logic                  s_hsel,
  output logic [ADDR_WIDTH-1:0] s_haddr,
  output logic [1:0]            s_htrans,
  output logic                  s_hwrite,
  output logic [DATA_WIDTH-1:0] s_hwdata,
  output logic                  s_hreadyi,
  input  logic [DATA_WIDTH-1:0] s_hrdata,
  input  logic                  s_hreadyo,
  input  logic [1:0]            s_hresp
);

  logic                  cand0, cand1;
  logic [ADDR_WIDTH-1:0] cand_addr0, cand_addr1;
  logic                  cand_write0, cand_write1;
  logic                  grant_valid;
  mst_id_t               grant_id;
  logic                  grant0, grant1;
  logic                  dp_valid_q, dp_valid_d;
  mst_id_t               dp_owner_q, dp_owner_d;
  logic                  dp_mine0, dp_mine1;
  logic                  unused_htrans;

  // Only htrans[1] matters: every granted beat is re-issued as NONSEQ.
  assign unused_htrans = m0_htrans[0] ^ m1_htrans[0];

  assign dp_mine0 = dp_valid_q & (dp_owner_q == 1'b0);
  assign dp_mine1 = dp_valid_q & (dp_owner_q == 1'b1);

  ahb2_arb_req_buf #(.ADDR_WIDTH(ADDR_WIDTH)) u_buf0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .hsel       (m0_hsel),
    .htrans_act (m0_htrans[1]),
    .haddr      (m0_haddr),
    .hwrite     (m0_hwrite),
    .grant      (grant0),
    .dp_mine    (dp_mine0),
    .s_hreadyo  (s_hreadyo),
    .cand       (cand0),
    .cand_addr  (cand_addr0),
    .cand_write (cand_write0),
    .hreadyo    (m0_hreadyo)
  );

  ahb2_arb_req_buf #(.ADDR_WIDTH(ADDR_WIDTH)) u_buf1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .hsel       (m1_hsel),
    .htrans_act (m1_htrans[1]),
    .haddr      (m1_haddr),
    .hwrite     (m1_hwrite),
    .grant      (grant1),
    .dp_mine    (dp_mine1),
    .s_hreadyo  (s_hreadyo),
    .cand       (cand1),
    .cand_addr  (cand_addr1),
    .cand_write (cand_write1),
    .hreadyo    (m1_hreadyo)
  );

`ifndef AHB2_MEM_ARB_FIXED_PRIO_EN
  mst_id_t last_grant_q, last_grant_d;

  assign last_grant_d = grant_valid ? grant_id : last_grant_q;

  // Reset to 1 so master 0 wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Grant only while the slave can accept an address phase.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (s_hreadyo) begin
      if (cand0 && cand1) begin
        grant_valid = 1'b1;
`ifdef AHB2_MEM_ARB_FIXED_PRIO_EN
        grant_id    = 1'b0;
`else
        grant_id    = ~last_grant_q;
`endif
      end else if (cand0) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (cand1) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign grant0 = grant_valid & (grant_id == 1'b0);
  assign grant1 = grant_valid & (grant_id == 1'b1);

  // Downstream address phase.
  always_comb begin
    s_hsel   = 1'b0;
    s_htrans = HTRANS_IDLE;
    s_haddr  = cand_addr0;
    s_hwrite = cand_write0;
    if (grant_valid) begin
      s_hsel   = 1'b1;
      s_htrans = HTRANS_NONSEQ;
      s_haddr  = grant_id ? cand_addr1  : cand_addr0;
      s_hwrite = grant_id ? cand_write1 : cand_write0;
    end
  end

  assign s_hreadyi = s_hreadyo;

  // Data-phase owner advances only when the slave completes a phase.
  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_owner_d = dp_owner_q;
    if (s_hreadyo) begin
      dp_valid_d = grant_valid;
      if (grant_valid) begin
        dp_owner_d = grant_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid_q <= 1'b0;
      dp_owner_q <= 1'b0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_owner_q <= dp_owner_d;
    end
  end

  // Data routing: only the data-phase owner sees slave data/response.
  always_comb begin
    s_hwdata  = dp_owner_q ? m1_hwdata : m0_hwdata;
    m0_hrdata = '0;
    m0_hresp  = HRESP_OKAY;
    m1_hrdata = '0;
    m1_hresp  = HRESP_OKAY;
    if (dp_mine0) begin
      m0_hrdata = s_hrdata;
      m0_hresp  = s_hresp;
    end
    if (dp_mine1) begin
      m1_hrdata = s_hrdata;
      m1_hresp  = s_hresp;
    end
  end

endmodule

// File: tb/tb_ahb2_mem_arb.sv
// tb_ahb2_mem_arb: directed testbench for ahb2_mem_arb with a behavioural
// single-port AHB memory slave. Define AHB2_MEM_ARB_FIXED_PRIO_EN to check
// the fixed-priority build.
module tb_ahb2_mem_arb;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          m0_hsel = 1'b0, m1_hsel = 1'b0;
  logic [AW-1:0] m0_haddr = '0, m1_haddr = '0;
  logic [1:0]    m0_htrans = 2'b00, m1_htrans = 2'b00;
  logic          m0_hwrite = 1'b0, m1_hwrite = 1'b0;
  logic [DW-1:0] m0_hwdata = '0, m1_hwdata = '0;
  logic [DW-1:0] m0_hrdata, m1_hrdata;
  logic          m0_hreadyo, m1_hreadyo;
  logic [1:0]    m0_hresp, m1_hresp;
  logic          s_hsel, s_hwrite, s_hreadyi;
  logic [AW-1:0] s_haddr;
  logic [1:0]    s_htrans;
  logic [DW-1:0] s_hwdata, s_hrdata;
  logic          s_hreadyo;
  logic [1:0]    s_hresp;
  logic          stall = 1'b0;

  int checks = 0;
  int errors = 0;

  ahb2_mem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0_hsel    (m0_hsel),
    .m0_haddr   (m0_haddr),
    .m0_htrans  (m0_htrans),
    .m0_hwrite  (m0_hwrite),
    .m0_hwdata  (m0_hwdata),
    .m0_hrdata  (m0_hrdata),
    .m0_hreadyo (m0_hreadyo),
    .m0_hresp   (m0_hresp),
    .m1_hsel    (m1_hsel),
    .m1_haddr   (m1_haddr),
    .m1_htrans  (m1_htrans),
    .m1_hwrite  (m1_hwrite),
    .m1_hwdata  (m1_hwdata),
    .m1_hrdata  (m1_hrdata),
    .m1_hreadyo (m1_hreadyo),
    .m1_hresp   (m1_hresp),
    .s_hsel     (s_hsel),
    .s_haddr    (s_haddr),
    .s_htrans   (s_htrans),
    .s_hwrite   (s_hwrite),
    .s_hwdata   (s_hwdata),
    .s_hreadyi  (s_hreadyi),
    .s_hrdata   (s_hrdata),
    .s_hreadyo  (s_hreadyo),
    .s_hresp    (s_hresp)
  );

  // ---------------- memory slave model ----------------
  // Unwritten word i reads as 32'h5A000000 | i.
  logic [DW-1:0] mem [0:255];
  bit            mem_init = 1'b0;
  logic          sl_dp_v, sl_dp_w;
  logic [AW-1:0] sl_dp_a;

  assign s_hreadyo = ~stall;
  assign s_hresp   = 2'b00;
  assign s_hrdata  = (sl_dp_v && !sl_dp_w) ? mem[sl_dp_a[9:2]] : '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_dp_v <= 1'b0;
      sl_dp_w <= 1'b0;
      sl_dp_a <= '0;
    end else if (s_hreadyi) begin
      sl_dp_v <= s_hsel && s_htrans[1];
      sl_dp_w <= s_hwrite;
      sl_dp_a <= s_haddr;
    end
  end

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h5A00_0000 | i;
      mem_init <= 1'b1;
    end else if (s_hreadyi && sl_dp_v && sl_dp_w) begin
      mem[sl_dp_a[9:2]] <= s_hwdata;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic act, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    m0_hsel = act; m0_htrans = act ? 2'b10 : 2'b00; m0_haddr = a; m0_hwrite = w; m0_hwdata = d;
  endtask

  task automatic set_m1(input logic act, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    m1_hsel = act; m1_htrans = act ? 2'b10 : 2'b00; m1_haddr = a; m1_hwrite = w; m1_hwdata = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int act_cnt;
    #1;
    checks++; if (m0_hreadyo !== 1'b1) begin errors++; $display("FAIL rst_m0_hreadyo got=%0h exp=1", m0_hreadyo); end
    checks++; if (m1_hreadyo !== 1'b1) begin errors++; $display("FAIL rst_m1_hreadyo got=%0h exp=1", m1_hreadyo); end
    checks++; if (s_htrans !== 2'b00) begin errors++; $display("FAIL rst_s_htrans got=%0h exp=0", s_htrans); end
    checks++; if (s_hsel !== 1'b0) begin errors++; $display("FAIL rst_s_hsel got=%0h exp=0", s_hsel); end
    checks++; if (m0_hrdata !== 32'h0) begin errors++; $display("FAIL rst_m0_hrdata got=%0h exp=0", m0_hrdata); end
    tick();
    tick();
    rst_n = 1'b1;
    act_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (s_htrans !== 2'b00) act_cnt++;
    end
    checks++; if (act_cnt !== 0) begin errors++; $display("FAIL idle_after_rst busy_cycles=%0d exp=0", act_cnt); end
  endtask

  task automatic test_contention();
    tick();  // T: both write
    set_m0(1, 32'h10, 1, '0);
    set_m1(1, 32'h20, 1, '0);
    @(negedge clk);
    checks++; if (s_haddr !== 32'h10) begin errors++; $display("FAIL cont_T_haddr got=%0h exp=10", s_haddr); end
    checks++; if (s_hwrite !== 1'b1) begin errors++; $display("FAIL cont_T_hwrite got=%0h exp=1", s_hwrite); end
    tick();  // T+1
    set_m0(0, '0, 0, 32'hA);
    set_m1(0, '0, 0, 32'hB);
    @(negedge clk);
    checks++; if (m1_hreadyo !== 1'b0) begin errors++; $display("FAIL cont_T1_m1_hreadyo got=%0h exp=0", m1_hreadyo); end
    checks++; if (s_haddr !== 32'h20) begin errors++; $display("FAIL cont_T1_haddr got=%0h exp=20", s_haddr); end
    checks++; if (s_hwdata !== 32'hA) begin errors++; $display("FAIL cont_T1_hwdata got=%0h exp=a", s_hwdata); end
    checks++; if (m0_hreadyo !== 1'b1) begin errors++; $display("FAIL cont_T1_m0_hreadyo got=%0h exp=1", m0_hreadyo); end
    tick();  // T+2
    @(negedge clk);
    checks++; if (m1_hreadyo !== 1'b1) begin errors++; $display("FAIL cont_T2_m1_hreadyo got=%0h exp=1", m1_hreadyo); end
    checks++; if (s_hwdata !== 32'hB) begin errors++; $display("FAIL cont_T2_hwdata got=%0h exp=b", s_hwdata); end
    tick();  // readback: both read in the same cycle
    set_m0(1, 32'h10, 0, '0);
    set_m1(1, 32'h20, 0, '0);
    @(negedge clk);
    checks++; if (s_haddr !== 32'h10) begin errors++; $display("FAIL rb_R0_haddr got=%0h exp=10", s_haddr); end
    tick();
    set_m0(0, '0, 0, '0);
    set_m1(0, '0, 0, '0);
    @(negedge clk);
    checks++; if (m0_hrdata !== 32'hA) begin errors++; $display("FAIL rb_m0_hrdata got=%0h exp=a", m0_hrdata); end
    checks++; if (m1_hreadyo !== 1'b0) begin errors++; $display("FAIL rb_m1_wait got=%0h exp=0", m1_hreadyo); end
    checks++; if (s_haddr !== 32'h20) begin errors++; $display("FAIL rb_R1_haddr got=%0h exp=20", s_haddr); end
    tick();
    @(negedge clk);
    checks++; if (m1_hrdata !== 32'hB) begin errors++; $display("FAIL rb_m1_hrdata got=%0h exp=b", m1_hrdata); end
    checks++; if (m1_hreadyo !== 1'b1) begin errors++; $display("FAIL rb_m1_hreadyo got=%0h exp=1", m1_hreadyo); end
    checks++; if (m0_hrdata !== 32'h0) begin errors++; $display("FAIL rb_m0_nonowner got=%0h exp=0", m0_hrdata); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] exp_addr [8];
    int idx0, idx1, run0, run1, max0, max1, bad_addr, m1_ready_cnt;
    logic h0, h1;
    bit drained;
`ifdef AHB2_MEM_ARB_FIXED_PRIO_EN
    exp_addr = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h210, 32'h214, 32'h218, 32'h21C};
`else
    exp_addr = '{32'h200, 32'h300, 32'h204, 32'h304, 32'h208, 32'h308, 32'h20C, 32'h30C};
`endif
    idx0 = 0; idx1 = 0; run0 = 0; run1 = 0; max0 = 0; max1 = 0; bad_addr = 0; m1_ready_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      set_m0(1, 32'h200 + 4 * idx0, 0, '0);
      set_m1(1, 32'h300 + 4 * idx1, 0, '0);
      @(negedge clk);
      h0 = m0_hreadyo;
      h1 = m1_hreadyo;
      if (s_htrans !== 2'b10 || s_haddr !== exp_addr[c]) begin
        bad_addr++;
        $display("FAIL b2b_grant cycle=%0d got=%0h exp=%0h", c, s_haddr, exp_addr[c]);
      end
      if (c > 0 && h1 === 1'b1) m1_ready_cnt++;
      run0 = h0 ? 0 : run0 + 1;
      run1 = h1 ? 0 : run1 + 1;
      if (run0 > max0) max0 = run0;
      if (run1 > max1) max1 = run1;
      if (h0) idx0++;
      if (h1) idx1++;
    end
    checks++; if (bad_addr !== 0) begin errors++; $display("FAIL b2b_order bad_cycles=%0d exp=0", bad_addr); end
`ifdef AHB2_MEM_ARB_FIXED_PRIO_EN
    checks++; if (m1_ready_cnt !== 0) begin errors++; $display("FAIL b2b_m1_starved ready_cycles=%0d exp=0", m1_ready_cnt); end
    checks++; if (max0 !== 0) begin errors++; $display("FAIL b2b_m0_waits got=%0d exp=0", max0); end
`else
    checks++; if (max0 > 1) begin errors++; $display("FAIL b2b_m0_waits got=%0d exp<=1", max0); end
    checks++; if (max1 > 1) begin errors++; $display("FAIL b2b_m1_waits got=%0d exp<=1", max1); end
`endif
    tick();
    set_m0(0, '0, 0, '0);
    set_m1(0, '0, 0, '0);
    drained = 1'b0;
    for (int i = 0; i < 12 && !drained; i++) begin
      @(negedge clk);
      if (m0_hreadyo === 1'b1 && m1_hreadyo === 1'b1 && s_htrans === 2'b00) drained = 1'b1;
      else tick();
    end
    checks++; if (!drained) begin errors++; $display("FAIL b2b_drain timeout got=0 exp=1"); end
  endtask

  task automatic test_stall();
    int m0_wait;
    tick();  // S0
    set_m0(1, 32'h10, 0, '0);
    @(negedge clk);
    checks++; if (s_haddr !== 32'h10) begin errors++; $display("FAIL stall_S0_haddr got=%0h exp=10", s_haddr); end
    tick();  // S1: stall begins, m1 issues read of 0x40
    set_m0(0, '0, 0, '0);
    set_m1(1, 32'h40, 0, '0);
    stall = 1'b1;
    @(negedge clk);
    m0_wait = (m0_hreadyo === 1'b0) ? 1 : 0;
    checks++; if (s_htrans !== 2'b00 || s_hsel !== 1'b0) begin errors++; $display("FAIL stall_S1_idle got=%0h exp=0", s_htrans); end
    checks++; if (m1_hreadyo !== 1'b1) begin errors++; $display("FAIL stall_S1_m1_hreadyo got=%0h exp=1", m1_hreadyo); end
    tick();  // S2
    set_m1(0, '0, 0, '0);
    @(negedge clk);
    if (m0_hreadyo === 1'b0) m0_wait++;
    checks++; if (m1_hreadyo !== 1'b0) begin errors++; $display("FAIL stall_pend1 got=%0h exp=0", m1_hreadyo); end
    checks++; if (s_htrans !== 2'b00) begin errors++; $display("FAIL stall_S2_idle got=%0h exp=0", s_htrans); end
    tick();  // S3
    @(negedge clk);
    if (m0_hreadyo === 1'b0) m0_wait++;
    checks++; if (s_htrans !== 2'b00) begin errors++; $display("FAIL stall_S3_idle got=%0h exp=0", s_htrans); end
    tick();  // S4: slave ready again
    stall = 1'b0;
    @(negedge clk);
    checks++; if (m0_wait !== 3) begin errors++; $display("FAIL stall_m0_waits got=%0d exp=3", m0_wait); end
    checks++; if (m0_hreadyo !== 1'b1) begin errors++; $display("FAIL stall_S4_m0_hreadyo got=%0h exp=1", m0_hreadyo); end
    checks++; if (m0_hrdata !== 32'hA) begin errors++; $display("FAIL stall_m0_hrdata got=%0h exp=a", m0_hrdata); end
    checks++; if (s_htrans !== 2'b10 || s_haddr !== 32'h40) begin errors++; $display("FAIL stall_m1_issue got=%0h exp=40", s_haddr); end
    tick();  // S5
    @(negedge clk);
    checks++; if (m1_hreadyo !== 1'b1) begin errors++; $display("FAIL stall_S5_m1_hreadyo got=%0h exp=1", m1_hreadyo); end
    checks++; if (m1_hrdata !== 32'h5A00_0010) begin errors++; $display("FAIL stall_m1_hrdata got=%0h exp=5a000010", m1_hrdata); end
  endtask

  task automatic test_reset_mid();
    int act_cnt;
    tick();  // m0 reads 0x10, m1 writes 0x20 <- 0x77 (will be dropped)
    set_m0(1, 32'h10, 0, '0);
    set_m1(1, 32'h20, 1, '0);
    @(negedge clk);
    checks++; if (s_haddr !== 32'h10) begin errors++; $display("FAIL rmid_haddr got=%0h exp=10", s_haddr); end
    tick();
    set_m0(0, '0, 0, '0);
    set_m1(0, '0, 0, 32'h77);
    checks++; if (m1_hreadyo !== 1'b0) begin errors++; $display("FAIL rmid_pend1 got=%0h exp=0", m1_hreadyo); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (m1_hreadyo !== 1'b1) begin errors++; $display("FAIL rmid_m1_hreadyo got=%0h exp=1", m1_hreadyo); end
    checks++; if (s_hsel !== 1'b0 || s_htrans !== 2'b00) begin errors++; $display("FAIL rmid_s_idle got=%0h exp=0", s_htrans); end
    checks++; if (m0_hrdata !== 32'h0) begin errors++; $display("FAIL rmid_m0_hrdata got=%0h exp=0", m0_hrdata); end
    tick();
    rst_n = 1'b1;
    act_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (s_htrans !== 2'b00) act_cnt++;
    end
    checks++; if (act_cnt !== 0) begin errors++; $display("FAIL rmid_replay busy_cycles=%0d exp=0", act_cnt); end
    tick();
    set_m1(1, 32'h20, 0, '0);
    @(negedge clk);
    checks++; if (s_haddr !== 32'h20 || m1_hreadyo !== 1'b1) begin errors++; $display("FAIL rmid_rd_issue got=%0h exp=20", s_haddr); end
    tick();
    set_m1(0, '0, 0, '0);
    @(negedge clk);
    checks++; if (m1_hrdata !== 32'hB) begin errors++; $display("FAIL rmid_no_write got=%0h exp=b", m1_hrdata); end
  endtask

  task automatic test_single();
    int low_cnt;
    low_cnt = 0;
    tick();
    set_m0(1, 32'h100, 1, '0);
    @(negedge clk);
    if (m0_hreadyo !== 1'b1) low_cnt++;
    checks++; if (s_haddr !== 32'h100 || s_hwrite !== 1'b1) begin errors++; $display("FAIL single_wr_addr got=%0h exp=100", s_haddr); end
    tick();
    set_m0(1, 32'h100, 0, 32'hDEAD_BEEF);
    @(negedge clk);
    if (m0_hreadyo !== 1'b1) low_cnt++;
    checks++; if (s_hwdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_hwdata got=%0h exp=deadbeef", s_hwdata); end
    checks++; if (s_hwrite !== 1'b0 || s_htrans !== 2'b10) begin errors++; $display("FAIL single_rd_issue got=%0h exp=0", s_hwrite); end
    tick();
    set_m0(0, '0, 0, '0);
    @(negedge clk);
    if (m0_hreadyo !== 1'b1) low_cnt++;
    checks++; if (m0_hrdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_hrdata got=%0h exp=deadbeef", m0_hrdata); end
    checks++; if (low_cnt !== 0) begin errors++; $display("FAIL single_no_wait low_cycles=%0d exp=0", low_cnt); end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_contention();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_single();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb2_mem_arb.md
Name: ahb2_mem_arb

Overview:
- Two-master AHB2 arbiter placed in front of the single-port AHB2 memory slave, so two requesters (e.g. CPU and DMA) share one memory.
- Arbitrates each transfer independently.
- Buffers the losing master's address phase and inserts wait states for that master.
- Routes write data to the memory, and read data and response back to the data-phase owner.

Parameters:
- ADDR_WIDTH, 32, width of haddr on both master ports and the slave port.
- DATA_WIDTH, 32, width of hwdata/hrdata.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- mN_hsel  in  1  master N (N=0,1) select.
- mN_haddr  in  ADDR_WIDTH  master N address.
- mN_htrans  in  2  master N transfer type; bit[1] marks an active transfer.
- mN_hwrite  in  1  master N write.
- mN_hwdata  in  DATA_WIDTH  master N write data.
- mN_hrdata  out  DATA_WIDTH  read data to master N.
- mN_hreadyo  out  1  ready to master N; also fed back by master N as its hreadyi.
- mN_hresp  out  2  response to master N.
- s_hsel, s_haddr, s_htrans, s_hwrite, s_hwdata, s_hreadyi  out  1/ADDR_WIDTH/2/1/DATA_WIDTH/1  signals to the memory slave.
- s_hrdata  in  DATA_WIDTH  read data from the slave.
- s_hreadyo  in  1  slave ready.
- s_hresp  in  2  slave response.

Behaviour:
- Reset values (async, rst_n=0):
  - pendN=0, dp_valid=0, last_grant=1 (so master 0 wins first).
  - mN_hreadyo=1, mN_hresp=HRESP_OKAY, mN_hrdata=0.
  - s_hsel=0, s_htrans=IDLE.
- New request N: mN_hsel & mN_htrans[1] & mN_hreadyo.
- Candidate N: pendN | new request N. A buffered request sources from the pend registers (addr, write); a new request sources live from the port.
- Grant: only when s_hreadyo=1.
  - One candidate: it is granted.
  - Both candidates: round-robin; the master != last_grant wins. last_grant updates on every grant.
- Downstream address phase (combinational from grant):
  - s_hsel=1, s_htrans=NONSEQ, s_haddr/s_hwrite from the granted source, s_hreadyi=s_hreadyo.
  - With no grant: s_hsel=0, s_htrans=IDLE.
- Losing or stalled new request N: captured into pendN (addr, write), pendN<=1.
- Granted pendN: cleared on the next edge.
- Data-phase owner:
  - dp_owner<=granted master and dp_valid<=1 on a grant edge, only when s_hreadyo=1.
  - dp_valid<=0 when s_hreadyo=1 with no grant.
  - dp_owner/dp_valid hold while s_hreadyo=0.
- Data routing:
  - s_hwdata = m[dp_owner]_hwdata.
  - m[dp_owner]_hrdata = s_hrdata and m[dp_owner]_hresp = s_hresp.
  - Non-owner: hrdata=0, hresp=OKAY.
- mN_hreadyo:
  - 0 if pendN=1.
  - Else if dp_valid & dp_owner==N, equals s_hreadyo.
  - Else 1.
- Latency:
  - Uncontended transfer: 0 wait states.
  - Loser: exactly 1 wait state per lost round, while a pending master holds its next address.
- HSEQ, hburst and hsize are ignored; every beat is arbitrated as NONSEQ.
- Slave stall (s_hreadyo=0): no new grant. Other masters' new requests are captured into their pend registers; pend entries are never lost or duplicated.
- Mid-operation rst_n: all pending and in-flight state is dropped immediately; outputs return to their reset values.

Optional Feature:
- Macro AHB2_MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Master 0 always wins when it is a candidate; master 1 is granted only when master 0 has no candidate. last_grant is unused.
- Undefined: round-robin as above.

Decomposition:
- Package ahb2_pkg holds:
  - HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10, HRESP_OKAY=2'b00.
  - typedef mst_id_t (1 bit).
- Sub-module ahb2_arb_req_buf, instantiated per master:
  - Holds the pend register (valid, addr, write).
  - Drives the candidate/address-mux outputs and mN_hreadyo generation.
  - Inputs: grant, dp ownership, s_hreadyo.
- Top level holds the arbitration, last_grant, dp_owner and data muxing.

Test Plan:
- Reset → with rst_n low: m0/m1_hreadyo=1, s_htrans=IDLE, s_hsel=0. Release rst_n, no requests → s_htrans stays IDLE.
- m0 writes 0xDEADBEEF to 0x100, then reads 0x100 → m0_hrdata=0xDEADBEEF, m0_hreadyo never 0.
- Simultaneous cycle T: m0 writes 0x10←0xA and m1 writes 0x20←0xB:
  - T: m0 granted.
  - T+1: m1_hreadyo=0, s_haddr=0x20.
  - T+2: m1_hreadyo=1.
  - Readback returns 0xA and 0xB.
- Both masters issue back-to-back reads for 8 cycles → grant order 0,1,0,1,…; each master sees ≤1 wait state per transfer. With AHB2_MEM_ARB_FIXED_PRIO_EN: all grants go to m0 and m1_hreadyo stays 0.
- Force s_hreadyo=0 for 3 cycles during an m0 data phase while m1 issues a read of 0x40 → m0_hreadyo=0 for 3 cycles, pend1 set, no s_htrans activity. m1's read is issued on the first cycle s_hreadyo=1 and returns correct data.
- Assert rst_n low while pend1=1 → m1_hreadyo=1 and pend1=0 immediately (asynchronously). After release, the dropped transfer is not replayed.
